imu_frame_assembler: RTL

- Sits directly downstream of the I2C master driver, one byte-level stream in, one frame-level stream out.
- Collects the byte stream the driver reads back from the inertial sensor burst read and packs it into one frame of NUM_AXES signed 16-bit samples.
- Each sample is received big-endian: high byte first.
- Presents the frame to the attitude/control logic through a valid/ready handshake.
- Tracks malformed bursts, timeouts and overruns.

---
 rtl/imu_frame_assembler_if.sv | 23 ++
 rtl/imu_frame_assembler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imu_frame_assembler_if.sv
// Byte-stream input and frame-stream output of the IMU frame assembler.
// The assembler takes the slave modport; the producer/consumer side takes master.
interface imu_frame_assembler_if #(
  parameter int unsigned NUM_AXES = 3
);
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_first;
  logic                   byte_err;
  logic [16*NUM_AXES-1:0] frame_data;
  logic                   frame_valid;
  logic                   frame_ready;

  modport master (
    output byte_data, byte_valid, byte_first, byte_err, frame_ready,
    input  frame_data, frame_valid
  );

  modport slave (
    input  byte_data, byte_valid, byte_first, byte_err, frame_ready,
    output frame_data, frame_valid
  );
endinterface

// File: rtl/imu_frame_assembler.sv
// Packs a big-endian byte burst into NUM_AXES signed 16-bit samples with a single-entry output buffer.
// Optional offset subtraction with saturation is enabled by defining IMU_FRAME_OFFSET_EN.
module imu_frame_assembler #(
  parameter int unsigned NUM_AXES       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imu_frame_assembler_if.slave   bus,
  input  logic [16*NUM_AXES-1:0] offset_in,
  output logic                   err_pulse,
  output logic [7:0]             drop_cnt,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int unsigned IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_AXES - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HI, LO, PUBLISH} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap;
  logic [16*NUM_AXES-1:0] stage;
  logic [16*NUM_AXES-1:0] pub;
  logic [16*NUM_AXES-1:0] frame_q;
  logic                   valid_q;

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = valid_q;

`ifdef IMU_FRAME_OFFSET_EN
  logic [16:0] diff;

  // 17-bit signed difference; bits 16 and 15 disagree only on overflow.
  always_comb begin
    pub  = '0;
    diff = '0;
    for (int unsigned a = 0; a < NUM_AXES; a++) begin
      diff = {stage[16*a+15], stage[16*a +: 16]} - {offset_in[16*a+15], offset_in[16*a +: 16]};
      if (diff[16] != diff[15])
        pub[16*a +: 16] = diff[16] ? 16'h8000 : 16'h7FFF;
      else
        pub[16*a +: 16] = diff[15:0];
    end
  end
`else
  logic unused_offset;

  assign unused_offset = ^offset_in;

  always_comb begin
    pub = stage;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      gap       <= '0;
      stage     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      err_pulse <= 1'b0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (valid_q && bus.frame_ready)
        valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.byte_valid && bus.byte_first) begin
            stage[15:8] <= bus.byte_data;
            idx         <= '0;
            gap         <= '0;
            state       <= LO;
          end
        end

        HI, LO: begin
          // Priority: abort, then resync/byte, then gap timeout.
          if (bus.byte_err) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else if (bus.byte_valid && bus.byte_first) begin
            err_pulse   <= 1'b1;
            stage[15:8] <= bus.byte_data;
            idx         <= '0;
            gap         <= '0;
            state       <= LO;
          end else if (bus.byte_valid) begin
            gap <= '0;
            if (state == HI) begin
              stage[{idx, 4'd8} +: 8] <= bus.byte_data;
              state                   <= LO;
            end else begin
              stage[{idx, 4'd0} +: 8] <= bus.byte_data;
              if (idx == LAST_IDX) begin
                state <= PUBLISH;
              end else begin
                idx   <= idx + 1'b1;
                state <= HI;
              end
            end
          end else if (gap == GAP_LIMIT) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end

        PUBLISH: begin
          state <= IDLE;
          if (!valid_q || bus.frame_ready) begin
            frame_q   <= pub;
            valid_q   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
